// File: rtl/timer_frequency_controller.sv
// timer_frequency_controller: button-stepped blink timer (OFF/1/2/5/10 Hz) with a
// one-cycle expiry tick and a toggling LED.
module timer_frequency_controller #(
   parameter int unsigned CLOCK_FREQUENCY_HZ = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       button,
   input  logic       hold,
   output logic       led,
   output logic       tick,
   output logic [2:0] state_index
);
   typedef enum logic [2:0] {OFF = 3'd0, F1 = 3'd1, F2 = 3'd2, F5 = 3'd3, F10 = 3'd4} state_t;
   localparam logic [31:0] L1  = 32'(CLOCK_FREQUENCY_HZ - 1);
   localparam logic [31:0] L2  = 32'(CLOCK_FREQUENCY_HZ / 2 - 1);
   localparam logic [31:0] L5  = 32'(CLOCK_FREQUENCY_HZ / 5 - 1);
   localparam logic [31:0] L10 = 32'(CLOCK_FREQUENCY_HZ / 10 - 1);
   state_t      state, next;
   logic [1:0]  btn_sync, hold_sync;
   logic        btn_prev, step, running;
   logic [31:0] count, last;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         btn_sync  <= '0;
         hold_sync <= '0;
         btn_prev  <= 1'b0;
      end else begin
         btn_sync  <= {btn_sync[0], button};
         hold_sync <= {hold_sync[0], hold};
         btn_prev  <= btn_sync[1];
      end
   assign step = btn_sync[1] & ~btn_prev;
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= OFF;
      else state <= next;
   // encodings 5-7 fall into default and recover to OFF on the next edge
   always_comb begin
      next = OFF;
      case (state)
         OFF:     next = step ? F1  : OFF;
         F1:      next = step ? F2  : F1;
         F2:      next = step ? F5  : F2;
         F5:      next = step ? F10 : F5;
         F10:     next = step ? OFF : F10;
         default: next = OFF;
      endcase
   end
   assign running     = state inside {F1, F2, F5, F10};
   assign last        = state == F1 ? L1 : state == F2 ? L2 : state == F5 ? L5 : L10;
   assign state_index = state;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         count <= '0;
         tick  <= 1'b0;
         led   <= 1'b0;
      end else if (step) begin
         count <= '0;
         tick  <= 1'b0;
         led   <= led & (next != OFF);
      end else if (!running) begin
         count <= '0;
         tick  <= 1'b0;
         led   <= 1'b0;
      end else if (hold_sync[1]) begin
         tick  <= 1'b0;
      end else if (count == last) begin
         count <= '0;
         tick  <= 1'b1;
         led   <= ~led;
      end else begin
         count <= count + 32'd1;
         tick  <= 1'b0;
      end
endmodule

// File: tb/tb_timer_frequency_controller.sv
// tb_timer_frequency_controller: directed scenarios plus random stimulus against a
// setting/phase reference model, with a 100 Hz clock so periods are 100/50/20/10.
module tb_timer_frequency_controller;
   localparam int FREQ = 100;
   logic       clock = 1'b0, reset = 1'b0, button = 1'b0, hold = 1'b0;
   logic       led, tick;
   logic [2:0] state_index;
   int         errors = 0, checks = 0;
   int         per [5] = '{0, 100, 50, 20, 10};

   timer_frequency_controller #(.CLOCK_FREQUENCY_HZ(FREQ)) dut (
      .clock(clock), .reset(reset), .button(button), .hold(hold),
      .led(led), .tick(tick), .state_index(state_index)
   );

   always #5 clock = ~clock;

   // reference: input samples seen at earlier edges, setting 0..4, phase within period
   logic [2:0] bh;
   logic [1:0] hh;
   int         m_set, m_phase;
   logic       m_led, m_tick;
   wire        m_step = bh[1] & ~bh[2];
   wire        m_hold = hh[1];
   always @(posedge clock or posedge reset)
      if (reset) begin
         bh <= '0; hh <= '0; m_set <= 0; m_phase <= 0; m_led <= 1'b0; m_tick <= 1'b0;
      end else begin
         bh <= {bh[1:0], button};
         hh <= {hh[0], hold};
         if (m_step) begin
            m_set <= (m_set + 1) % 5; m_phase <= 0; m_tick <= 1'b0;
            if (m_set == 4) m_led <= 1'b0;
         end else if (m_set == 0) begin
            m_phase <= 0; m_tick <= 1'b0; m_led <= 1'b0;
         end else if (m_hold) begin
            m_tick <= 1'b0;
         end else if (m_phase == per[m_set] - 1) begin
            m_phase <= 0; m_tick <= 1'b1; m_led <= ~m_led;
         end else begin
            m_phase <= m_phase + 1; m_tick <= 1'b0;
         end
      end

   // returns at the falling edge right after the edge on which the state changed
   task automatic step_now;
      repeat (2) @(negedge clock);
      button = 1'b1;
      repeat (3) @(negedge clock);
      button = 1'b0;
   endtask

   task automatic test_reset;
      int n;
      #1 reset = 1'b1;
      @(negedge clock);
      checks++;
      if ({led, tick, state_index} !== 5'b0) begin errors++; $display("FAIL reset_init: got %b expected 00000", {led, tick, state_index}); end
      reset = 1'b0;
      step_now; step_now;
      repeat (60) @(negedge clock);
      checks++;
      if (state_index !== 3'd2 || led !== 1'b1) begin errors++; $display("FAIL pre_reset: got led=%b idx=%0d expected led=1 idx=2", led, state_index); end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({led, tick, state_index} !== 5'b0) begin errors++; $display("FAIL async_reset: got %b expected 00000", {led, tick, state_index}); end
      @(negedge clock);
      reset = 1'b0;
      n = 0;
      repeat (500) begin @(negedge clock); if (tick) n++; end
      checks++;
      if (n != 0 || state_index !== 3'd0) begin errors++; $display("FAIL idle_after_reset: got ticks=%0d idx=%0d expected 0 0", n, state_index); end
   endtask

   task automatic test_stepping;
      logic [2:0] exp_idx [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      logic [2:0] prev;
      prev = 3'd0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) repeat (15) @(negedge clock);
         button = 1'b1;
         repeat (2) @(negedge clock);
         checks++;
         if (state_index !== prev) begin errors++; $display("FAIL step_early %0d: got %0d expected %0d", i, state_index, prev); end
         @(negedge clock);
         checks++;
         if (state_index !== exp_idx[i]) begin errors++; $display("FAIL step_state %0d: got %0d expected %0d", i, state_index, exp_idx[i]); end
         prev = exp_idx[i];
         @(negedge clock);
         button = 1'b0;
         repeat (4) @(negedge clock);
      end
      checks++;
      if (led !== 1'b0) begin errors++; $display("FAIL step_led_off: got %b expected 0", led); end
   endtask

   task automatic test_periods;
      int n;
      logic l;
      for (int k = 1; k <= 4; k++) begin
         step_now;
         for (int j = 0; j < 3; j++) begin
            l = led;
            n = 1;
            @(negedge clock);
            checks++;
            if (tick !== 1'b0) begin errors++; $display("FAIL tick_width F%0d: got %b expected 0", k, tick); end
            while (!tick && n < 500) begin @(negedge clock); n++; end
            checks++;
            if (n != per[k] || led !== ~l) begin errors++; $display("FAIL period F%0d/%0d: got %0d led=%b expected %0d led=%b", k, j, n, led, per[k], ~l); end
         end
      end
   endtask

   task automatic test_hold;
      int n, t;
      repeat (2) @(negedge clock);
      hold = 1'b1;
      t = 0;
      repeat (30) begin @(negedge clock); if (tick) t++; end
      hold = 1'b0;
      n = 0;
      do begin @(negedge clock); n++; end while (!tick && n < 100);
      checks++;
      if (t != 0) begin errors++; $display("FAIL hold_ticks: got %0d expected 0", t); end
      checks++;
      if (n != 8) begin errors++; $display("FAIL hold_resume: got %0d expected 8", n); end
   endtask

   task automatic test_collision;
      int n;
      logic l;
      repeat (7) @(negedge clock);
      button = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if ({tick, led, state_index} !== 5'b0) begin errors++; $display("FAIL collide_off: got %b expected 00000", {tick, led, state_index}); end
      button = 1'b0;
      step_now; step_now; step_now;
      n = 0;
      do begin @(negedge clock); n++; end while (!tick && n < 100);
      checks++;
      if (n != 20 || state_index !== 3'd3) begin errors++; $display("FAIL f5_first: got %0d idx=%0d expected 20 idx=3", n, state_index); end
      l = led;
      repeat (17) @(negedge clock);
      button = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if (tick !== 1'b0 || state_index !== 3'd4 || led !== l) begin errors++; $display("FAIL collide_f10: got tick=%b idx=%0d led=%b expected 0 4 %b", tick, state_index, led, l); end
      button = 1'b0;
      n = 0;
      do begin @(negedge clock); n++; end while (!tick && n < 100);
      checks++;
      if (n != 10) begin errors++; $display("FAIL f10_after_collide: got %0d expected 10", n); end
   endtask

   task automatic test_held_button;
      int steps, ticks, last;
      logic [2:0] s;
      step_now; step_now;
      repeat (30) @(negedge clock);
      s = state_index; steps = 0; ticks = 0; last = -1;
      checks++;
      if (s !== 3'd1) begin errors++; $display("FAIL held_start: got %0d expected 1", s); end
      button = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clock);
         if (state_index !== s) begin steps++; s = state_index; last = i; end
         if (tick) begin
            ticks++;
            checks++;
            if (last < 0 || i - last != 50) begin errors++; $display("FAIL held_spacing: got %0d expected 50", i - last); end
            last = i;
         end
      end
      button = 1'b0;
      checks++;
      if (steps != 1 || s !== 3'd2 || ticks != 5) begin errors++; $display("FAIL held_button: got steps=%0d idx=%0d ticks=%0d expected 1 2 5", steps, s, ticks); end
   endtask

   task automatic test_random;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         checks++;
         if ({led, tick, state_index} !== {m_led, m_tick, m_set[2:0]}) begin
            errors++;
            $display("FAIL random %0d: got %b expected %b", i, {led, tick, state_index}, {m_led, m_tick, m_set[2:0]});
         end
         if ($urandom_range(39) == 0) button = ~button;
         if ($urandom_range(59) == 0) hold = ~hold;
         if ($urandom_range(999) == 0) begin #2 reset = 1'b1; #1 reset = 1'b0; end
      end
      button = 1'b0;
      hold = 1'b0;
   endtask

   initial begin
      test_reset;
      test_stepping;
      test_periods;
      test_hold;
      test_collision;
      test_held_button;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
